// File: rtl/xdelay_bank.sv
// xdelay_bank: multi-channel run-time-configurable delay line.
// Each of N_CH channels delays its DATA_W word by 0..MAX_DELAY extra en-cycles
// using a circular buffer per channel and one shared write pointer.
// Delays are latched on a `run` pulse; `done` reports when every channel has
// been primed since the last run.
// Optional build macro: XDELAY_BANK_MASK_EN forces each channel's output to
// zero until that channel is primed, hiding stale buffer contents.
module xdelay_bank #(
    parameter int MAX_DELAY = 8,
    parameter int DATA_W    = 32,
    parameter int N_CH      = 4,
    parameter int DLY_W     = $clog2(MAX_DELAY) + 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    run,
    input  logic                    en,
    output logic                    done,
    input  logic [N_CH*DATA_W-1:0]  in_data,
    output logic [N_CH*DATA_W-1:0]  out_data,
    input  logic [N_CH*DLY_W-1:0]   delay
);

    // Pointer needs at least one bit even for a single-entry buffer.
    localparam int PTR_W = (MAX_DELAY > 1) ? $clog2(MAX_DELAY) : 1;
    localparam int CNT_W = $clog2(MAX_DELAY + 2);
    // Read index is formed as wptr + MAX_DELAY - d, which can reach
    // 2*MAX_DELAY-1 before the modulo fold.
    localparam int IDX_W = DLY_W + 2;
    // Common width for comparing the fill counter against delay values.
    localparam int CMP_W = CNT_W + DLY_W;

    localparam logic [DLY_W-1:0] DLY_MAX  = DLY_W'(MAX_DELAY);
    localparam logic [CNT_W-1:0] CNT_TOP  = CNT_W'(MAX_DELAY + 1);
    localparam logic [IDX_W-1:0] IDX_MAX  = IDX_W'(MAX_DELAY);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_DELAY - 1);

    // Architectural state
    logic [PTR_W-1:0]        wptr;
    logic [DLY_W-1:0]        d_reg [N_CH];
    logic [DLY_W-1:0]        dmax;
    logic [CNT_W-1:0]        cnt;
    logic [N_CH*DATA_W-1:0]  out_raw;
    logic [DATA_W-1:0]       mem [N_CH][MAX_DELAY];

    // Next-state helpers
    logic [DLY_W-1:0]        d_next [N_CH];
    logic [DLY_W-1:0]        dmax_new;
    logic [DLY_W-1:0]        dmax_next;
    logic [CNT_W-1:0]        cnt_next;
    logic [IDX_W-1:0]        rd_sum [N_CH];
    logic [PTR_W-1:0]        rd_idx [N_CH];
    logic [DATA_W-1:0]       rd_word [N_CH];
    logic                    done_next;

    // Effective per-channel delay for this cycle: a run pulse takes effect
    // immediately (saturated to MAX_DELAY), otherwise the latched value.
    always_comb begin
        dmax_new = '0;
        for (int c = 0; c < N_CH; c++) begin
            d_next[c] = d_reg[c];
            if (run) begin
                if (delay[c*DLY_W +: DLY_W] > DLY_MAX) begin
                    d_next[c] = DLY_MAX;
                end else begin
                    d_next[c] = delay[c*DLY_W +: DLY_W];
                end
            end
            if (d_next[c] > dmax_new) begin
                dmax_new = d_next[c];
            end
        end
        dmax_next = run ? dmax_new : dmax;
    end

    // Read side: index (wptr - d) mod MAX_DELAY, read before this cycle's
    // write; a zero delay bypasses the buffer entirely.
    always_comb begin
        for (int c = 0; c < N_CH; c++) begin
            rd_sum[c] = IDX_W'(wptr) + IDX_MAX - IDX_W'(d_next[c]);
            if (rd_sum[c] >= IDX_MAX) begin
                rd_sum[c] = rd_sum[c] - IDX_MAX;
            end
            rd_idx[c] = rd_sum[c][PTR_W-1:0];
            if (d_next[c] == '0) begin
                rd_word[c] = in_data[c*DATA_W +: DATA_W];
            end else begin
                rd_word[c] = mem[c][rd_idx[c]];
            end
        end
    end

    // Fill counter: restarts on run (counting the run cycle itself if en),
    // otherwise advances on en and saturates at MAX_DELAY+1.
    always_comb begin
        cnt_next = cnt;
        if (run) begin
            cnt_next = en ? CNT_W'(1) : '0;
        end else if (en && (cnt != CNT_TOP)) begin
            cnt_next = cnt + CNT_W'(1);
        end
        done_next = (CMP_W'(cnt_next) > CMP_W'(dmax_next));
    end

    // Control and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr    <= '0;
            cnt     <= CNT_TOP;
            dmax    <= '0;
            done    <= 1'b1;
            out_raw <= '0;
            for (int c = 0; c < N_CH; c++) begin
                d_reg[c] <= '0;
            end
        end else begin
            if (run) begin
                dmax <= dmax_next;
                for (int c = 0; c < N_CH; c++) begin
                    d_reg[c] <= d_next[c];
                end
            end
            cnt  <= cnt_next;
            done <= done_next;
            if (en) begin
                wptr <= (wptr == PTR_LAST) ? '0 : (wptr + PTR_W'(1));
                for (int c = 0; c < N_CH; c++) begin
                    out_raw[c*DATA_W +: DATA_W] <= rd_word[c];
                end
            end
        end
    end

    // Buffer storage: written at the shared pointer on every en cycle, never reset.
    always_ff @(posedge clk) begin
        if (en) begin
            for (int c = 0; c < N_CH; c++) begin
                mem[c][wptr] <= in_data[c*DATA_W +: DATA_W];
            end
        end
    end

`ifdef XDELAY_BANK_MASK_EN
    // Hide each channel's output until it is primed (cnt > d_c); driven only
    // from registers so the output stays glitch-free and input-independent.
    always_comb begin
        out_data = '0;
        for (int c = 0; c < N_CH; c++) begin
            if (CMP_W'(cnt) > CMP_W'(d_reg[c])) begin
                out_data[c*DATA_W +: DATA_W] = out_raw[c*DATA_W +: DATA_W];
            end
        end
    end
`else
    assign out_data = out_raw;
`endif

endmodule

// File: tb/tb_xdelay_bank.sv
// tb_xdelay_bank: self-checking bench for xdelay_bank.
// Directed scenarios plus a randomized phase, all compared against a
// behavioural model that keeps the full per-channel input history and looks
// back d_c samples, rather than modelling a circular buffer.
// Honours XDELAY_BANK_MASK_EN when the build defines it.
module tb_xdelay_bank;

    localparam int MAX_DELAY = 8;
    localparam int DATA_W    = 32;
    localparam int N_CH      = 4;
    localparam int DLY_W     = 4;
    localparam int HIST_N    = 2048;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   run;
    logic                   en;
    logic                   done;
    logic [N_CH*DATA_W-1:0] in_data;
    logic [N_CH*DATA_W-1:0] out_data;
    logic [N_CH*DLY_W-1:0]  delay;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model state
    logic [31:0] hist [N_CH][HIST_N];
    int          hlen;
    int          m_d [N_CH];
    int          m_dmax;
    int          m_cnt;
    bit          m_done;
    logic [31:0] m_out [N_CH];
    bit          m_known [N_CH];

    xdelay_bank #(
        .MAX_DELAY (MAX_DELAY),
        .DATA_W    (DATA_W),
        .N_CH      (N_CH),
        .DLY_W     (DLY_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .run      (run),
        .en       (en),
        .done     (done),
        .in_data  (in_data),
        .out_data (out_data),
        .delay    (delay)
    );

    // Free-running clock
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, got, want);
        end
    endtask

    function automatic logic [31:0] chOut(input int c);
        return out_data[c*DATA_W +: DATA_W];
    endfunction

    function automatic logic [N_CH*DATA_W-1:0] mkCount(input int base);
        logic [N_CH*DATA_W-1:0] v;
        for (int c = 0; c < N_CH; c++) begin
            v[c*DATA_W +: DATA_W] = 32'(100 * c + base);
        end
        return v;
    endfunction

    function automatic logic [N_CH*DATA_W-1:0] mkRand();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic modelStep(input bit rs, input bit r, input bit e,
                             input logic [N_CH*DLY_W-1:0] dl,
                             input logic [N_CH*DATA_W-1:0] din);
        int v;
        int idx;
        if (rs) begin
            hlen   = 0;
            m_cnt  = MAX_DELAY + 1;
            m_dmax = 0;
            m_done = 1'b1;
            for (int c = 0; c < N_CH; c++) begin
                m_d[c]     = 0;
                m_out[c]   = '0;
                m_known[c] = 1'b1;
            end
        end else begin
            if (r) begin
                m_dmax = 0;
                for (int c = 0; c < N_CH; c++) begin
                    v = int'(dl[c*DLY_W +: DLY_W]);
                    m_d[c] = (v > MAX_DELAY) ? MAX_DELAY : v;
                    if (m_d[c] > m_dmax) m_dmax = m_d[c];
                end
            end
            if (e) begin
                for (int c = 0; c < N_CH; c++) begin
                    hist[c][hlen] = din[c*DATA_W +: DATA_W];
                end
                hlen++;
                for (int c = 0; c < N_CH; c++) begin
                    idx = hlen - 1 - m_d[c];
                    if (idx >= 0) begin
                        m_out[c]   = hist[c][idx];
                        m_known[c] = 1'b1;
                    end else begin
                        m_known[c] = 1'b0;
                    end
                end
            end
            if (r) begin
                m_cnt = e ? 1 : 0;
            end else if (e && (m_cnt < MAX_DELAY + 1)) begin
                m_cnt++;
            end
            m_done = (m_cnt > m_dmax);
        end
    endtask

    task automatic compareModel();
        logic [31:0] want;
        bit          valid;
        for (int c = 0; c < N_CH; c++) begin
`ifdef XDELAY_BANK_MASK_EN
            if (m_cnt <= m_d[c]) begin
                want  = '0;
                valid = 1'b1;
            end else begin
                want  = m_out[c];
                valid = m_known[c];
            end
`else
            want  = m_out[c];
            valid = m_known[c];
`endif
            if (valid) checkOutput($sformatf("model_out_ch%0d", c), chOut(c), want);
        end
        checkOutput("model_done", 32'(done), 32'(m_done));
    endtask

    // One clock cycle: drive inputs, let the edge happen, advance the model,
    // then compare one time unit after the edge.
    task automatic applyStimulus(input bit rs, input bit r, input bit e,
                                 input logic [N_CH*DLY_W-1:0] dl,
                                 input logic [N_CH*DATA_W-1:0] din);
        rst     = rs;
        run     = r;
        en      = e;
        delay   = dl;
        in_data = din;
        @(posedge clk);
        modelStep(rs, r, e, dl, din);
        #1;
        compareModel();
        cyc++;
    endtask

    initial begin
        int t0;
        int k;
        int ne;
        int dA [N_CH];
        logic [31:0] s    [64];
        logic [N_CH*DATA_W-1:0] ins [64];
        logic [N_CH*DATA_W-1:0] din;
        logic [31:0] want;

        // Reset
        applyStimulus(1'b1, 1'b0, 1'b0, '0, '0);
        applyStimulus(1'b1, 1'b0, 1'b0, '0, '0);
        checkOutput("reset_done", 32'(done), 32'd1);
        for (int c = 0; c < N_CH; c++) checkOutput($sformatf("reset_out_ch%0d", c), chOut(c), 32'd0);

        // Delays {0,1,3,8}, counting data, continuous en
        dA[0] = 0; dA[1] = 1; dA[2] = 3; dA[3] = 8;
        t0 = cyc;
        for (int i = 0; i <= 20; i++) begin
            applyStimulus(1'b0, i == 0, 1'b1, 16'h8310, mkCount(t0 + i));
            checkOutput("basic_done", 32'(done), 32'(i >= 8));
            for (int c = 0; c < N_CH; c++) begin
                k = i - dA[c];
                if (k >= 0) checkOutput($sformatf("basic_ch%0d", c), chOut(c), 32'(100 * c + t0 + k));
            end
        end

        // Stall for 3 cycles with delay 2
        ne = 0;
        for (int i = 0; i < 14; i++) begin
            din = mkRand();
            applyStimulus(1'b0, i == 0, !(i >= 6 && i < 9), 16'h2222, din);
            if (!(i >= 6 && i < 9)) begin
                s[ne] = din[31:0];
                ne++;
            end
            checkOutput("stall_done", 32'(done), 32'(ne > 2));
            if (ne - 1 >= 2) checkOutput("stall_out", chOut(0), s[ne - 3]);
        end

        // Saturation (15 acts as 8) and wrap-around over 40 cycles
        for (int i = 0; i < 40; i++) begin
            ins[i] = mkRand();
            applyStimulus(1'b0, i == 0, 1'b1, 16'h8F8F, ins[i]);
            checkOutput("wrap_done", 32'(done), 32'(i >= 8));
            if (i >= 8) begin
                for (int c = 0; c < N_CH; c++) begin
                    checkOutput($sformatf("wrap_ch%0d", c), chOut(c), ins[i - 8][c*DATA_W +: DATA_W]);
                end
            end
        end

        // Re-run mid-priming with delays {2,2,2,2}
        for (int i = 0; i <= 10; i++) begin
            ins[i] = mkRand();
            applyStimulus(1'b0, (i == 0) || (i == 3), 1'b1, (i < 3) ? 16'h8888 : 16'h2222, ins[i]);
            checkOutput("rerun_done", 32'(done), 32'((i >= 3) && (i - 3 >= 2)));
            if (i >= 3) begin
                want = ins[i - 2][31:0];
`ifdef XDELAY_BANK_MASK_EN
                if (i - 3 < 2) want = '0;
`endif
                checkOutput("rerun_ch0", chOut(0), want);
            end
        end

        // Preload all-ones, then run with delay 4
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 16'h2222, {N_CH*DATA_W{1'b1}});
        end
        t0 = cyc;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b0, i == 0, 1'b1, 16'h4444, mkCount(t0 + i));
            for (int c = 0; c < N_CH; c++) begin
                if (i < 4) begin
`ifdef XDELAY_BANK_MASK_EN
                    want = 32'h0000_0000;
`else
                    want = 32'hFFFF_FFFF;
`endif
                end else begin
                    want = 32'(100 * c + t0 + i - 4);
                end
                checkOutput($sformatf("preload_ch%0d", c), chOut(c), want);
            end
        end

        // Reset during priming
        applyStimulus(1'b0, 1'b1, 1'b1, 16'h8888, mkRand());
        applyStimulus(1'b0, 1'b0, 1'b1, 16'h8888, mkRand());
        applyStimulus(1'b1, 1'b0, 1'b1, 16'h8888, mkRand());
        checkOutput("midrst_done", 32'(done), 32'd1);
        checkOutput("midrst_wptr", 32'(dut.wptr), 32'd0);
        for (int c = 0; c < N_CH; c++) checkOutput($sformatf("midrst_ch%0d", c), chOut(c), 32'd0);
        for (int i = 0; i < 4; i++) begin
            din = mkRand();
            applyStimulus(1'b0, 1'b0, 1'b1, 16'h0000, din);
            checkOutput("midrst_pass", chOut(1), din[63:32]);
        end

        // Randomized traffic: occasional run/reset, random stalls and delays
        for (int i = 0; i < 200; i++) begin
            applyStimulus($urandom_range(0, 99) == 0,
                          $urandom_range(0, 9) == 0,
                          $urandom_range(0, 4) != 0,
                          16'($urandom()),
                          mkRand());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/xdelay_bank.md
# xdelay_bank

Multi-channel, run-time-configurable delay line. Successor to the single-channel Versat delay unit. Each of N_CH channels delays its DATA_W word by 0..MAX_DELAY extra cycles. Delay values are latched per run, and the pipeline can be stalled. It sits in the Versat datapath between functional units to align operand streams, and reports through `done` when every channel's pipeline is primed.

## Interface
- `MAX_DELAY`, 8: maximum extra delay per channel; buffer depth; any value ≥ 1, not required to be a power of two.
- `DATA_W`, 32: width of one channel's data word.
- `N_CH`, 4: number of independent channels.
- `DLY_W`, $clog2(MAX_DELAY)+1 (derived): width of one delay field.

Ports:
- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `run`  in  1  one-cycle pulse: latch `delay`, restart priming.
- `en`  in  1  advance enable; when low, all state holds.
- `done`  out  1  high when all channels primed since the last `run`.
- `in_data`  in  N_CH*DATA_W  channel c at bits [c*DATA_W +: DATA_W].
- `out_data`  out  N_CH*DATA_W  registered delayed data, same packing.
- `delay`  in  N_CH*DLY_W  channel c extra delay at [c*DLY_W +: DLY_W]; sampled only on `run`.

## Operation
- Per channel: circular buffer `mem_c[0..MAX_DELAY-1]`. One write pointer `wptr` is shared by all channels and runs 0..MAX_DELAY-1, wrapping to 0.
- Latched delay `d_c`:
  - Loaded from `delay` on `run`.
  - Values > MAX_DELAY saturate to MAX_DELAY.
  - `dmax` = max over c of `d_c`, registered at the same time.
- On a cycle with `en`=1, for each channel:
  - `mem_c[wptr]` <= `in_c`.
  - `out_c` <= `in_c` if `d_c`=0; otherwise `out_c` <= `mem_c[(wptr - d_c) mod MAX_DELAY]`, read before write.
  - For `d_c`=MAX_DELAY, the read index equals `wptr`, so the old contents are read.
  - `wptr` advances by 1 with wrap.
- `en`=0: `mem`, `wptr`, `out_data` and the fill counter hold.
- Fill counter `cnt`:
  - Width $clog2(MAX_DELAY+2).
  - On `run`: `cnt` <= `en`.
  - Otherwise, on each `en` cycle, `cnt` increments, saturating at MAX_DELAY+1.
- `done` = (`cnt` > `dmax`), registered so it updates with `cnt`.
- Channel c primed = (`cnt` > `d_c`).
- `run` and `en` in the same cycle:
  - The new `d_c` is used for that cycle's read.
  - That cycle's input is sample 0 of the new run.
- `run` mid-priming or mid-stream:
  - Restarts priming with the new delays; `done` drops the next cycle if `cnt` resets below `dmax`+1.
  - Buffer contents are not cleared.
- Reset values:
  - `out_data` = 0, `done` = 1, `wptr` = 0.
  - `cnt` = MAX_DELAY+1, and all `d_c` = 0, `dmax` = 0.
  - `mem` is not reset.
- `rst` mid-run aborts priming immediately and returns to the reset state.

## Timing
- Latency: a sample presented with `en`=1 in cycle t appears on `out_c` in the cycle after the d_c-th subsequent `en` cycle. With continuous `en`, that is cycle t+d_c+1.
- Throughput: one word per channel per `en` cycle; no bubbles.
- After `run` in cycle t0 with continuous `en`:
  - `done`=0 from t0+1.
  - `done`=1 from t0+dmax+1, the first cycle the slowest channel shows sample 0.
- If `run` arrives with `dmax`=0 and `en`=1, `done` stays 1.
- `done` does not depend combinationally on any input.

## Configuration
- `XDELAY_BANK_MASK_EN` defined:
  - `out_c` is forced to 0 while channel c is unprimed (`cnt` ≤ `d_c`).
  - Stale buffer data never reaches the output after `run`.
- Undefined:
  - `out_data` is the raw buffer read.
  - Before priming it carries leftover data from the previous run, or X after power-up.
  - No masking logic is instantiated.

## Test plan
- Reset, then `run` with delays {0,1,3,8}, continuous `en`, `in_c` = 100·c + cycle index:
  - Sample k appears on channel c at cycle t0+k+d_c+1.
  - `done` is 0 for cycles t0+1..t0+8 and 1 from t0+9.
- Delay field 15 with MAX_DELAY=8: behaves exactly as 8, the saturation case.
- Stall: `en` low for 3 cycles mid-stream with delay 2.
  - `out_data` and `done` hold during the stall.
  - The sequence resumes with no lost or duplicated samples; latency grows by exactly 3 cycles.
- Wrap-around: 40 cycles continuous, delay 8. The output matches input shifted by 9 across ≥4 pointer wraps.
- Re-`run` mid-priming (cycle t0+3) with delays {2,2,2,2}: `done`=0 until the new t0+3, and the new delays are used from the `run` cycle.
- With `XDELAY_BANK_MASK_EN`:
  - Preload the buffer with 0xFFFF_FFFF, then `run` with delay 4.
  - `out` is 0 for 4 cycles, then valid data. Without the macro, 0xFFFF_FFFF is visible in those cycles.
- `rst` asserted at t0+2 of priming: next cycle `out_data`=0, `done`=1, `wptr`=0.
